// File: rtl/enc8to3_rr_arbiter_if.sv
// rtl/enc8to3_rr_arbiter_if.sv - request/grant bundle between bus sources and the round-robin arbiter
//
// Signals:
//   en    - arbiter enable (master -> arbiter)
//   req   - 8-bit multi-hot request vector, bit i = requester i (master -> arbiter)
//   done  - current owner releases the bus (master -> arbiter)
//   grant - registered one-hot grant, zero when idle (arbiter -> master)
//   idx   - registered binary index of the granted requester (arbiter -> master)
//   valid - high while grant/idx are meaningful (arbiter -> master)
// Modports: master drives en/req/done; slave (the arbiter) drives grant/idx/valid.

interface enc8to3_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;

    modport master (
        output en,
        output req,
        output done,
        input  grant,
        input  idx,
        input  valid
    );

    modport slave (
        input  en,
        input  req,
        input  done,
        output grant,
        output idx,
        output valid
    );
endinterface

// File: rtl/enc8to3_rr_arbiter.sv
// rtl/enc8to3_rr_arbiter.sv - 8-way round-robin arbiter with registered one-hot grant and binary index
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, dominant over every other input
//   bus - enc8to3_rr_arbiter_if.slave: en/req/done in, grant/idx/valid out
//
// The pointer ptr_q names the highest-priority requester. The request vector is
// rotated so that position ptr_q lands at bit 0, the lowest set bit is found,
// and the offset is added back to ptr_q to recover the absolute winner. All
// outputs come straight from flops, so req/done never reach an output
// combinationally.

module enc8to3_rr_arbiter #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    enc8to3_rr_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q,   ptr_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [2*N-1:0]    req_dbl;
    logic [N-1:0]      req_rot;
    logic [IDXW-1:0]   off;
    logic [IDXW-1:0]   winner;
    logic              any_req;

    // Doubling the vector turns the rotate into a plain indexed slice.
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[ptr_q +: N];
    assign any_req = |bus.req;

    // Lowest set bit of the rotated vector is the first requester at or after ptr_q.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDXW'(i);
            end
        end
    end

    // Adding back the pointer undoes the rotation; the 3-bit sum wraps mod 8.
    assign winner = ptr_q + off;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.en && any_req) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Abort takes precedence over done and leaves the priority untouched.
                if (!bus.en) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.done) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + IDXW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_enc8to3_rr_arbiter.sv
// tb/tb_enc8to3_rr_arbiter.sv - self-checking bench for enc8to3_rr_arbiter

module tb_enc8to3_rr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   cmp_on;

    enc8to3_rr_arbiter_if bus ();

    enc8to3_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a granted flag, the priority pointer, and the visible outputs.
    bit         m_busy;
    int         m_ptr;
    int         m_idx;
    logic [7:0] m_grant;
    bit         m_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_idx = 0; m_grant = 8'h00; m_valid = 0;
        end else if (!m_busy) begin
            if (bus.en && bus.req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.req[(m_ptr + k) % 8]) begin
                        m_idx = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_grant = 8'h00;
                m_grant[m_idx] = 1'b1;
                m_valid = 1;
                m_busy  = 1;
            end
        end else if (!bus.en) begin
            m_grant = 8'h00; m_valid = 0; m_busy = 0;
        end else if (bus.done) begin
            m_grant = 8'h00; m_valid = 0; m_busy = 0;
            m_ptr   = (m_idx + 1) % 8;
        end
    end

    // Per-cycle comparison against the model plus the output invariants.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("grant", {24'd0, bus.grant}, {24'd0, m_grant});
            chk("idx",   {29'd0, bus.idx},   m_idx);
            chk("valid", {31'd0, bus.valid}, {31'd0, m_valid});
            chk("inv_onehot", ($countones(bus.grant) <= 1), 1);
            chk("inv_valid_iff_grant", {31'd0, bus.valid}, {31'd0, (bus.grant != 8'h00)});
            if (bus.valid)
                chk("inv_grant_eq_idx", {24'd0, bus.grant}, {24'd0, (8'h01 << bus.idx)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] g, input logic [2:0] i, input logic v);
        chk({name, "_grant"}, {24'd0, bus.grant}, {24'd0, g});
        chk({name, "_idx"},   {29'd0, bus.idx},   {29'd0, i});
        chk({name, "_valid"}, {31'd0, bus.valid}, {31'd0, v});
    endtask

    initial begin
        int fair_exp [4];
        fair_exp = '{0, 7, 0, 7};
        n_checks = 0; n_errors = 0; cmp_on = 0;
        rst = 1; bus.en = 0; bus.req = 8'h00; bus.done = 0;

        // Reset then single request
        tick(); tick();
        cmp_on = 1;
        lit("reset", 8'h00, 3'd0, 1'b0);
        rst = 0; bus.en = 1; bus.req = 8'h10;
        tick();
        lit("single", 8'h10, 3'd4, 1'b1);
        bus.done = 1; bus.req = 8'h00;
        tick();
        lit("single_rel", 8'h00, 3'd4, 1'b0);
        bus.done = 0; bus.req = 8'h21;   // ptr=5 must beat requester 0
        tick();
        lit("ptr5", 8'h20, 3'd5, 1'b1);
        bus.done = 1; bus.req = 8'h00;
        tick();
        bus.done = 0;

        // Round-robin fairness from ptr=0
        rst = 1; tick(); rst = 0;
        bus.req = 8'h81;
        tick();
        for (int n = 0; n < 4; n++) begin
            chk("fair_idx", {29'd0, bus.idx}, fair_exp[n]);
            chk("fair_valid", {31'd0, bus.valid}, 1);
            bus.done = 1;
            if (n == 3) bus.req = 8'hFF;
            tick();
            chk("fair_gap", {31'd0, bus.valid}, 0);
            bus.done = 0;
            tick();
        end

        // Wrap-around: Idx=7 released, ptr=0, req=FF
        lit("wrap", 8'h01, 3'd0, 1'b1);
        bus.done = 1; bus.req = 8'h00;
        tick();
        bus.done = 0;

        // Hold: owner drops its request with done low
        bus.req = 8'h04;
        tick();
        lit("hold_start", 8'h04, 3'd2, 1'b1);
        bus.req = 8'h00;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("hold_grant", {24'd0, bus.grant}, 32'h04);
        end
        bus.done = 1;
        tick();
        tick();
        lit("idle_done", 8'h00, 3'd2, 1'b0);
        bus.done = 0;

        // Abort via en, ptr stays at 3
        bus.req = 8'h08;
        tick();
        lit("abort_start", 8'h08, 3'd3, 1'b1);
        bus.en = 0;
        tick();
        lit("abort", 8'h00, 3'd3, 1'b0);
        bus.en = 1; bus.req = 8'h18;
        tick();
        lit("abort_regrant", 8'h08, 3'd3, 1'b1);
        bus.done = 1; bus.req = 8'h00;
        tick();
        bus.done = 0;

        // Reset mid-grant together with done
        bus.req = 8'h40;
        tick();
        lit("mid_start", 8'h40, 3'd6, 1'b1);
        rst = 1; bus.done = 1;
        tick();
        lit("mid_reset", 8'h00, 3'd0, 1'b0);
        rst = 0; bus.done = 0; bus.req = 8'hFF;
        tick();
        lit("mid_regrant", 8'h01, 3'd0, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) < 2);
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.done = ($urandom_range(0, 9) < 3);
            bus.req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
